// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI scheduler and its arbiter.
package spi_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after pointer, wrapping.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    any_req   = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(pointer) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_idx  = IW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_scheduler.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant, single
// spi_en launch, cs-tracked completion, launch timeout and inter-frame gap.
//   state  | meaning
//   IDLE   | waiting for any req; arbitrate and launch on the edge one is seen
//   LAUNCH | spi_en issued, waiting for cs low (bounded by LAUNCH_TIMEOUT)
//   BUSY   | frame in progress, waiting for cs to return high
//   GAP    | holding off GAP_CYCLES cycles before the next frame
module spi_master_scheduler
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int GAP_CYCLES     = 16,
  parameter int LAUNCH_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          busy,
  output logic                          spi_en,
  output logic [DATA_WIDTH-1:0]         spi_din,
  input  logic                          spi_cs
);

  localparam int IW = cnt_width(NUM_REQ);
  localparam int LW = cnt_width(LAUNCH_TIMEOUT);
  localparam int GW = cnt_width(GAP_CYCLES + 1);

  state_t                 state, state_d;
  logic [IW-1:0]          pointer, pointer_d, grant_idx, grant_idx_d, arb_idx;
  logic [NUM_REQ-1:0]     arb_grant;
  logic                   any_req;
  logic [LW-1:0]          launch_cnt, launch_cnt_d;
  logic [GW-1:0]          gap_cnt, gap_cnt_d;
  logic                   launch_expired, gap_last;
  logic [NUM_REQ-1:0]     ack_d, done_d;
  logic                   err_d, busy_d, spi_en_d;
  logic [DATA_WIDTH-1:0]  spi_din_d;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .pointer   (pointer),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  assign launch_expired = spi_cs && (launch_cnt == LW'(LAUNCH_TIMEOUT - 1));
  // With GAP_CYCLES=0 a timeout still passes through GAP for a single cycle.
  assign gap_last       = (int'(gap_cnt) >= GAP_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pointer    <= '0;
      grant_idx  <= '0;
      launch_cnt <= '0;
      gap_cnt    <= '0;
      ack        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      spi_en     <= 1'b0;
      spi_din    <= '0;
    end else begin
      state      <= state_d;
      pointer    <= pointer_d;
      grant_idx  <= grant_idx_d;
      launch_cnt <= launch_cnt_d;
      gap_cnt    <= gap_cnt_d;
      ack        <= ack_d;
      done       <= done_d;
      err        <= err_d;
      busy       <= busy_d;
      spi_en     <= spi_en_d;
      spi_din    <= spi_din_d;
    end
  end

  always_comb begin
    state_d      = state;
    pointer_d    = pointer;
    grant_idx_d  = grant_idx;
    launch_cnt_d = launch_cnt;
    gap_cnt_d    = gap_cnt;
    case (state)
      IDLE: if (any_req) begin
        state_d      = LAUNCH;
        grant_idx_d  = arb_idx;
        pointer_d    = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        launch_cnt_d = '0;
      end
      LAUNCH: begin
        if (!spi_cs) begin
          state_d      = BUSY;
          launch_cnt_d = '0;
        end else if (launch_expired) begin
          state_d      = GAP;
          launch_cnt_d = '0;
        end else begin
          launch_cnt_d = launch_cnt + 1'b1;
        end
      end
      BUSY: if (spi_cs) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP: begin
        if (gap_last) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    spi_en_d  = 1'b0;
    spi_din_d = spi_din;
    busy_d    = (state_d != IDLE);
    case (state)
      IDLE: if (any_req) begin
        ack_d     = arb_grant;
        spi_en_d  = 1'b1;
        spi_din_d = req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      LAUNCH:  if (launch_expired) err_d = 1'b1;
      BUSY:    if (spi_cs) done_d = NUM_REQ'(1) << grant_idx;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Scoreboard bench for spi_master_scheduler with a behavioural cs model.
module tb_spi_master_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0, req_g0 = '0;
  logic [N*DW-1:0] req_data = '0, req_data_g0 = '0;
  logic [N-1:0]    ack, done, ack_g0, done_g0;
  logic            err, busy, spi_en, spi_cs, err_g0, busy_g0, spi_en_g0, spi_cs_g0;
  logic [DW-1:0]   spi_din, spi_din_g0;
  bit              model_on = 1'b1;

  spi_master_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(16), .LAUNCH_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .err(err), .busy(busy), .spi_en(spi_en), .spi_din(spi_din), .spi_cs(spi_cs));

  spi_master_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(0), .LAUNCH_TIMEOUT(8)) dut_g0 (
    .clk(clk), .reset_n(reset_n), .req(req_g0), .req_data(req_data_g0), .ack(ack_g0), .done(done_g0),
    .err(err_g0), .busy(busy_g0), .spi_en(spi_en_g0), .spi_din(spi_din_g0), .spi_cs(spi_cs_g0));

  // cs model: falls 3 edges after spi_en is seen high, rises 10 edges later.
  int cs_cnt, cs_cnt_g0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs <= 1'b1; cs_cnt <= 0;
    end else if (cs_cnt == 0) begin
      if (spi_en && model_on) cs_cnt <= 1;
    end else begin
      if (cs_cnt == 2) spi_cs <= 1'b0;
      if (cs_cnt == 12) begin spi_cs <= 1'b1; cs_cnt <= 0; end
      else cs_cnt <= cs_cnt + 1;
    end
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs_g0 <= 1'b1; cs_cnt_g0 <= 0;
    end else if (cs_cnt_g0 == 0) begin
      if (spi_en_g0) cs_cnt_g0 <= 1;
    end else begin
      if (cs_cnt_g0 == 2) spi_cs_g0 <= 1'b0;
      if (cs_cnt_g0 == 12) begin spi_cs_g0 <= 1'b1; cs_cnt_g0 <= 0; end
      else cs_cnt_g0 <= cs_cnt_g0 + 1;
    end
  end

  typedef struct { int idx; logic [DW-1:0] data; bit timeout; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   err_pending = 0;
  int   checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic expect_grant(input int idx, input logic [DW-1:0] data, input bit timeout);
    exp_t e;
    e.idx = idx; e.data = data; e.timeout = timeout;
    exp_q.push_back(e);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!reset_n) begin
      done_q.delete();
      err_pending = 0;
    end else begin
      if (spi_en || ack != '0) begin
        if (exp_q.size() == 0) check("unexpected_ack", 64'(ack), 0);
        else begin
          e = exp_q.pop_front();
          check("ack_grant", 64'(ack), 64'(1) << e.idx);
          check("spi_din", 64'(spi_din), 64'(e.data));
          check("spi_en", 64'(spi_en), 1);
          check("busy_on_ack", 64'(busy), 1);
          if (e.timeout) err_pending++;
          else done_q.push_back(e.idx);
        end
      end
      if (done != '0) begin
        if (done_q.size() == 0) check("unexpected_done", 64'(done), 0);
        else begin
          d = done_q.pop_front();
          check("done_grant", 64'(done), 64'(1) << d);
        end
        check("done_ack_overlap", 64'(ack), 0);
        check("done_err_overlap", 64'(err), 0);
      end
      if (err) begin
        check("err_expected", 64'(err_pending > 0), 1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  function automatic logic sig(input int w);
    case (w)
      0:       return ack != '0;
      1:       return done != '0;
      2:       return err;
      3:       return !busy;
      default: return done_g0 != '0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!sig(w) && cyc < 300);
    if (!sig(w)) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     64'(ack), 0);
    check({tag, "_done"},    64'(done), 0);
    check({tag, "_err"},     64'(err), 0);
    check({tag, "_busy"},    64'(busy), 0);
    check({tag, "_spi_en"},  64'(spi_en), 0);
    check({tag, "_spi_din"}, 64'(spi_din), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_g0_busy", 64'(busy_g0), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Round robin from pointer 0; requester 0 re-requests and wins again last.
    for (int i = 0; i < N; i++) set_word(i, DW'(8'h10 + i));
    for (int k = 0; k < 5; k++) expect_grant(k % N, DW'(8'h10 + (k % N)), 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_for(0, "rr_ack", c);
      if (k > 0) check("rr_frame_spacing", 64'(c), 31);
      if (k != 0) req[k % N] = 1'b0;
    end
    wait_for(3, "rr_idle", c);

    // Single request: latency, data hold after ack, done and gap timing.
    set_word(2, 8'hA5);
    expect_grant(2, 8'hA5, 1'b0);
    req = 4'b0100;
    wait_for(0, "single_ack", c);
    check("single_ack_latency", 64'(c), 1);
    req = 4'b0000;
    set_word(2, 8'h5A);
    wait_for(1, "single_done", c);
    check("single_done_delay", 64'(c), 14);
    check("single_din_held", 64'(spi_din), 64'(8'hA5));
    wait_for(3, "single_idle", c);
    check("single_gap_len", 64'(c), 16);

    // Pointer wrap: grant 3, then 4'b1001 serves 0 before 3.
    expect_grant(3, 8'h13, 1'b0);
    req = 4'b1000;
    wait_for(0, "wrap3_ack", c);
    req = 4'b0000;
    wait_for(3, "wrap3_idle", c);
    expect_grant(0, 8'h10, 1'b0);
    expect_grant(3, 8'h13, 1'b0);
    req = 4'b1001;
    wait_for(0, "wrap_ack0", c);
    req[0] = 1'b0;
    wait_for(0, "wrap_ack3", c);
    req[3] = 1'b0;
    wait_for(3, "wrap_idle", c);

    // Launch timeout with cs held high, then a clean re-grant.
    model_on = 1'b0;
    set_word(0, 8'h3C);
    expect_grant(0, 8'h3C, 1'b1);
    req = 4'b0001;
    wait_for(0, "to_ack", c);
    req = 4'b0000;
    wait_for(2, "to_err", c);
    check("to_err_delay", 64'(c), 8);
    wait_for(3, "to_idle", c);
    check("to_gap_len", 64'(c), 16);
    model_on = 1'b1;
    expect_grant(0, 8'h3C, 1'b0);
    req = 4'b0001;
    wait_for(0, "to_regrant", c);
    check("to_regrant_latency", 64'(c), 1);
    req = 4'b0000;
    wait_for(3, "to_regrant_idle", c);

    // Reset while BUSY; pointer must restart at 0 so 4'b1010 serves 1 first.
    set_word(2, 8'h77);
    expect_grant(2, 8'h77, 1'b0);
    req = 4'b0100;
    wait_for(0, "rst_ack", c);
    req = 4'b0000;
    repeat (6) @(negedge clk);
    check("rst_busy_before", 64'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_word(1, 8'h21);
    set_word(3, 8'h23);
    expect_grant(1, 8'h21, 1'b0);
    expect_grant(3, 8'h23, 1'b0);
    req = 4'b1010;
    wait_for(0, "post_rst_ack1", c);
    req[1] = 1'b0;
    wait_for(0, "post_rst_ack3", c);
    req[3] = 1'b0;
    wait_for(3, "post_rst_idle", c);

    // GAP_CYCLES=0 instance: next spi_en one cycle after each done.
    req_data_g0[DW-1:0] = 8'h42;
    req_g0 = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      wait_for(4, "g0_done", c);
      check("g0_done_grant", 64'(done_g0), 1);
      check("g0_no_en_with_done", 64'(spi_en_g0), 0);
      @(negedge clk);
      check("g0_spi_en_after_done", 64'(spi_en_g0), 1);
      check("g0_ack_after_done", 64'(ack_g0), 1);
      check("g0_din", 64'(spi_din_g0), 64'(8'h42));
    end
    req_g0 = 4'b0000;
    repeat (20) @(negedge clk);

    check("left_expected_grants", 64'(exp_q.size()), 0);
    check("left_expected_dones", 64'(done_q.size()), 0);
    check("left_expected_errs", 64'(err_pending), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_scheduler.md
Name: spi_master_scheduler

Overview:
Shares one spi_master instance between NUM_REQ independent requesters. It arbitrates requests round-robin, latches the winner's word and launches one frame with a single-cycle spi_en pulse. It tracks the frame through the master's cs line, reports completion to the winner, then enforces a programmable inter-frame gap. It sits between the requester blocks and spi_master; the parent drives spi_master.reset from ~reset_n.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, SPI word width; must equal spi_master DATA_WIDTH
GAP_CYCLES, 16, clk cycles cs stays high between frames (0 allowed)
LAUNCH_TIMEOUT, 8, clk cycles to wait for cs low after spi_en before flagging error (>=4)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; hold with data until ack
req_data  input  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_REQ  one-hot, 1-cycle pulse: word accepted and launched
done  output  NUM_REQ  one-hot, 1-cycle pulse: frame finished (cs returned high)
err  output  1  1-cycle pulse: launch timeout
busy  output  1  high in every state except IDLE
spi_en  output  1  to spi_master en; 1-cycle pulse
spi_din  output  DATA_WIDTH  to spi_master din; held stable from launch until return to IDLE
spi_cs  input  1  from spi_master cs; active low

Behaviour:
- Reset (async, reset_n=0): state IDLE; ack=0, done=0, err=0, busy=0, spi_en=0, spi_din=0; RR pointer=0; counters=0. Takes effect immediately, mid-frame included. No done is issued for an aborted frame.
- All outputs are registered. States: IDLE, LAUNCH, BUSY, GAP.
- IDLE: if any req bit is high at a clk edge, the winner g is the first set bit at or after the pointer, wrapping modulo NUM_REQ. On that edge: spi_din<=req_data[g], spi_en<=1, ack[g]<=1, grant index<=g, pointer<=(g+1) mod NUM_REQ, state<=LAUNCH. With no req, the block stays in IDLE.
- Latency: req sampled high at edge t -> ack/spi_en visible after edge t, for exactly one cycle.
- LAUNCH: spi_en and ack return to 0. The launch counter increments every cycle. If spi_cs=0, go to BUSY and clear the counter. If the counter reaches LAUNCH_TIMEOUT-1 with spi_cs still 1, pulse err and go to GAP; done is not asserted.
- BUSY: wait for spi_cs=1. On that edge, done[grant]<=1 and state<=GAP, or IDLE when GAP_CYCLES=0.
- GAP: the gap counter counts GAP_CYCLES cycles, then the block goes to IDLE. It then clears the counter. Requests are ignored here; their req stays pending.
- Fairness: a requester that holds req is granted within NUM_REQ frames.
- A requester can re-request immediately after ack; the new request is served no earlier than the next IDLE.
- A req that drops before ack is never granted. A req_data change after ack has no effect on the frame in flight.
- Simultaneous events:
  - The done pulse and a new ack never share a cycle.
  - An err pulse never coexists with done.
  - spi_cs rising in the same cycle the block enters BUSY is not possible with spi_master, so no handling is required.
- Widths:
  - grant index and pointer: $clog2(NUM_REQ).
  - launch counter: $clog2(LAUNCH_TIMEOUT).
  - gap counter: $clog2(GAP_CYCLES+1), minimum 1 bit.
  - Counters saturate or clear as described; they never wrap.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum typedef (IDLE, LAUNCH, BUSY, GAP), 2 bits;
  - localparam helpers for counter widths;
  - a DATA_WIDTH default shared with spi_master.
- One sub-module, spi_rr_arbiter. Inputs: req, pointer. Outputs: grant one-hot, grant index, any_req. It is purely combinational; the pointer register lives in spi_master_scheduler.

Test Plan:
- Single request: NUM_REQ=4, req=4'b0100 with req_data[2]=8'hA5 -> ack=4'b0100 for 1 cycle, spi_en 1 cycle, spi_din=8'hA5, spi_master mosi shifts A5 LSB-first, done=4'b0100 one cycle after cs rises, busy low after GAP_CYCLES.
- Round-robin: req=4'b1111 held with words 8'h10/11/12/13 -> ack order 0,1,2,3,0; done pulses in the same order; cs high between frames for ≥GAP_CYCLES clks.
- Pointer wrap: after a grant to requester 3, req=4'b1001 -> requester 0 granted next, then 3.
- Launch timeout: spi_cs tied 1, req=4'b0001 -> err pulses LAUNCH_TIMEOUT cycles after ack, no done, block returns to IDLE after the gap and re-grants requester 0.
- Reset mid-frame: reset_n=0 while in BUSY -> all outputs 0 immediately, pointer 0. After release, req=4'b0010 gets ack=4'b0010 with no stale done.
- GAP_CYCLES=0: back-to-back req=4'b0001 -> the next spi_en is issued one cycle after the done pulse.
